// File: rtl/iiitb_seq_gen_pkg.sv
// Shared types and constants for the iiitb_seq_gen serial pattern generator.
// The optional PRBS gap fill is enabled by the macro IIITB_SEQ_GEN_PRBS_EN.
package iiitb_seq_gen_pkg;

    localparam int PAT_W_DEFAULT = 16;
    localparam int DIV_W_DEFAULT = 8;

    // PRBS-7, x^7 + x^6 + 1: feedback taps are register bits 6 and 5.
    localparam int         LFSR_W    = 7;
    localparam logic [6:0] LFSR_SEED = 7'h7F;
    localparam logic [6:0] LFSR_TAPS = 7'h60;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Fibonacci shift-left step; the new bit enters at the LSB.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/iiitb_seq_gen_baud.sv
// Bit-period timer: a down-counter that emits a one-cycle tick on the last
// cycle of every (div+1)-cycle bit period. restart_i reloads it at accept so
// the first bit period is aligned to the cycle after the handshake.
module iiitb_seq_gen_baud #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             restart_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;

    // Count down through the bit period, reloading after each tick.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (restart_i) begin
            cnt_q <= load_i;
        end else if (en_i) begin
            if (cnt_q == '0) begin
                cnt_q <= div_i;
            end else begin
                cnt_q <= cnt_q - DIV_W'(1);
            end
        end
    end

    assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/iiitb_seq_gen.sv
// Serial pattern generator: sends pattern[pat_len:0] MSB-first, each bit held
// baud_div+1 cycles, repeated repeat_cnt times (0 = until abort) with gap_bits
// idle bit periods between repetitions. Define IIITB_SEQ_GEN_PRBS_EN to fill
// the gap periods from a free-running PRBS-7 instead of zeros.
module iiitb_seq_gen
    import iiitb_seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEFAULT,
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [PAT_W-1:0]         pattern,
    input  logic [$clog2(PAT_W)-1:0] pat_len,
    input  logic [7:0]               repeat_cnt,
    input  logic [3:0]               gap_bits,
    input  logic [DIV_W-1:0]         baud_div,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic                     abort,
    output logic                     sequence_out,
    output logic                     bit_strobe,
    output logic                     busy,
    output logic                     done
);

    localparam int LEN_W = $clog2(PAT_W);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [7:0]       rep_q, rep_d;
    logic [3:0]       gap_q, gap_d;
    logic [3:0]       gcnt_q, gcnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             seq_q, seq_d;
    logic             strobe_q, strobe_d;
    logic             done_q, done_d;

    logic accept;
    logic tick;
    logic gap_bit;

    assign start_ready  = (state_q == ST_IDLE) && !abort;
    assign accept       = start_valid && start_ready;
    assign busy         = (state_q != ST_IDLE);
    assign sequence_out = seq_q;
    assign bit_strobe   = strobe_q;
    assign done         = done_q;

    iiitb_seq_gen_baud #(
        .DIV_W(DIV_W)
    ) u_baud (
        .clk_i    (clock),
        .rst_i    (reset),
        .restart_i(accept),
        .en_i     ((state_q == ST_SEND) || (state_q == ST_GAP)),
        .load_i   (baud_div),
        .div_i    (div_q),
        .tick_o   (tick)
    );

    // Next-state and next-output logic; outputs are registered alongside state.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        idx_d    = idx_q;
        rep_d    = rep_q;
        gap_d    = gap_q;
        gcnt_d   = gcnt_q;
        div_d    = div_q;
        seq_d    = seq_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                seq_d = 1'b0;
                if (accept) begin
                    pat_d    = pattern;
                    len_d    = pat_len;
                    rep_d    = repeat_cnt;
                    gap_d    = gap_bits;
                    div_d    = baud_div;
                    idx_d    = pat_len;
                    seq_d    = pattern[pat_len];
                    strobe_d = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    seq_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (idx_q != '0) begin
                        idx_d    = idx_q - LEN_W'(1);
                        seq_d    = pat_q[idx_d];
                        strobe_d = 1'b1;
                    end else if (rep_q == 8'd1) begin
                        // Last bit of the last repetition.
                        seq_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        // A count of zero means run forever, so never decrement it.
                        if (rep_q != 8'd0) begin
                            rep_d = rep_q - 8'd1;
                        end
                        if (gap_q != 4'd0) begin
                            gcnt_d  = gap_q - 4'd1;
                            seq_d   = gap_bit;
                            state_d = ST_GAP;
                        end else begin
                            idx_d    = len_q;
                            seq_d    = pat_q[len_q];
                            strobe_d = 1'b1;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    seq_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (gcnt_q == 4'd0) begin
                        idx_d    = len_q;
                        seq_d    = pat_q[len_q];
                        strobe_d = 1'b1;
                        state_d  = ST_SEND;
                    end else begin
                        gcnt_d = gcnt_q - 4'd1;
                        seq_d  = gap_bit;
                    end
                end
            end
            ST_FINISH: begin
                // done is high for exactly this cycle; abort is ignored here.
                seq_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                seq_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pat_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            rep_q    <= '0;
            gap_q    <= '0;
            gcnt_q   <= '0;
            div_q    <= '0;
            seq_q    <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            rep_q    <= rep_d;
            gap_q    <= gap_d;
            gcnt_q   <= gcnt_d;
            div_q    <= div_d;
            seq_q    <= seq_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

`ifdef IIITB_SEQ_GEN_PRBS_EN
    logic [LFSR_W-1:0] lfsr_q;
    logic              gap_adv;

    // One LFSR step per gap bit period actually emitted.
    assign gap_adv = tick && (state_d == ST_GAP);
    assign gap_bit = lfsr_q[LFSR_W-1];

    // Free-running across transmissions; only reset reseeds it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (gap_adv) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end
`else
    assign gap_bit = 1'b0;
`endif

endmodule

// File: tb/tb_iiitb_seq_gen.sv
// Directed self-checking bench for iiitb_seq_gen. Expected waveforms are
// hand-written bit vectors, LSB = first cycle after the accepting edge.
module tb_iiitb_seq_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pattern = '0;
    logic [3:0]  pat_len = '0;
    logic [7:0]  repeat_cnt = '0;
    logic [3:0]  gap_bits = '0;
    logic [7:0]  baud_div = '0;
    logic        start_valid = 1'b0;
    logic        abort = 1'b0;
    logic        start_ready, sequence_out, bit_strobe, busy, done;

    int n_assert = 0;
    int n_fail   = 0;

    // Loopback detector for 1011 (overlapping), fed from sequence_out.
    logic [2:0] det_sh;
    logic       det_clr = 1'b0;
    int         det_hits;

    iiitb_seq_gen #(.PAT_W(16), .DIV_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .pattern     (pattern),
        .pat_len     (pat_len),
        .repeat_cnt  (repeat_cnt),
        .gap_bits    (gap_bits),
        .baud_div    (baud_div),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .abort       (abort),
        .sequence_out(sequence_out),
        .bit_strobe  (bit_strobe),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (det_clr) begin
            det_sh   <= 3'b000;
            det_hits <= 0;
        end else begin
            det_sh <= {det_sh[1:0], sequence_out};
            if ({det_sh, sequence_out} == 4'b1011) det_hits <= det_hits + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge of cycle 1.
    // Inputs are scrambled after accept to show they were latched.
    task automatic start_tx(input logic [15:0] p, input logic [3:0] l, input logic [7:0] r,
                            input logic [3:0] g, input logic [7:0] d);
        pattern = p; pat_len = l; repeat_cnt = r; gap_bits = g; baud_div = d;
        start_valid = 1'b1;
        chk("ready_before_accept", 32'(start_ready), 32'd1);
        @(negedge clock);
        start_valid = 1'b0;
        pattern = ~p; pat_len = 4'd15; repeat_cnt = 8'd0; gap_bits = 4'd7; baud_div = 8'd9;
    endtask

    // Check n consecutive cycles starting at the current negedge.
    task automatic expect_run(input string tag, input int n, input logic [31:0] s,
                              input logic [31:0] st, input logic [31:0] dn, input logic [31:0] bz);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_seq_c%0d", tag, i + 1), 32'(sequence_out), 32'(s[i]));
            chk($sformatf("%s_strobe_c%0d", tag, i + 1), 32'(bit_strobe), 32'(st[i]));
            chk($sformatf("%s_done_c%0d", tag, i + 1), 32'(done), 32'(dn[i]));
            chk($sformatf("%s_busy_c%0d", tag, i + 1), 32'(busy), 32'(bz[i]));
            if (i != n - 1) @(negedge clock);
        end
        $display("txn %s: %0d cycles checked", tag, n);
    endtask

    initial begin
        logic [31:0] gap_seq;

        // Reset state while reset is held.
        @(negedge clock);
        @(negedge clock);
        chk("rst_seq", 32'(sequence_out), 32'd0);
        chk("rst_strobe", 32'(bit_strobe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", 32'(start_ready), 32'd1);
        $display("txn reset: released");

        // 1011, one bit per cycle, done at cycle 5.
        start_tx(16'h000B, 4'd3, 8'd1, 4'd0, 8'd0);
        expect_run("basic", 6, 32'b001101, 32'b001111, 32'b010000, 32'b011111);

        // Same pattern, three cycles per bit; strobes at 1,4,7,10, done at 13.
        @(negedge clock);
        start_tx(16'h000B, 4'd3, 8'd1, 4'd0, 8'd2);
        expect_run("baud2", 14, 32'b00111111000111, 32'b00001001001001,
                   32'b01000000000000, 32'b01111111111111);

        // Two repetitions with two gap bits: 1011 gg 1011, done at 11.
`ifdef IIITB_SEQ_GEN_PRBS_EN
        gap_seq = 32'b001101111101;
`else
        gap_seq = 32'b001101001101;
`endif
        @(negedge clock);
        start_tx(16'h000B, 4'd3, 8'd2, 4'd2, 8'd0);
        expect_run("gap2", 12, gap_seq, 32'b001111001111, 32'b010000000000, 32'b011111111111);

        // Abort on the second bit; then abort beats a simultaneous start.
        @(negedge clock);
        start_tx(16'h000B, 4'd3, 8'd1, 4'd0, 8'd0);
        chk("abort_c1_seq", 32'(sequence_out), 32'd1);
        @(negedge clock);
        chk("abort_c2_seq", 32'(sequence_out), 32'd0);
        chk("abort_c2_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clock);
        chk("abort_c3_seq", 32'(sequence_out), 32'd0);
        chk("abort_c3_busy", 32'(busy), 32'd0);
        chk("abort_c3_done", 32'(done), 32'd0);
        abort = 1'b0;
        #1;
        chk("abort_c3_ready", 32'(start_ready), 32'd1);
        abort = 1'b1;
        start_valid = 1'b1;
        #1;
        chk("abort_prio_ready", 32'(start_ready), 32'd0);
        @(negedge clock);
        chk("abort_prio_busy", 32'(busy), 32'd0);
        abort = 1'b0;
        start_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk($sformatf("abort_nodone_%0d", i), 32'(done), 32'd0);
        end
        $display("txn abort: checked");

        // Reset asserted between edges in the middle of a bit.
        start_tx(16'h000B, 4'd3, 8'd1, 4'd0, 8'd2);
        chk("midrst_pre_seq", 32'(sequence_out), 32'd1);
        chk("midrst_pre_strobe", 32'(bit_strobe), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_seq", 32'(sequence_out), 32'd0);
        chk("midrst_strobe", 32'(bit_strobe), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_ready", 32'(start_ready), 32'd1);
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            chk($sformatf("midrst_nodone_%0d", i), 32'(done | busy), 32'd0);
        end
        $display("txn midreset: checked");

        // Loopback into a 1011 detector, three back-to-back repetitions.
        det_clr = 1'b1;
        @(negedge clock);
        det_clr = 1'b0;
        start_tx(16'h000B, 4'd3, 8'd3, 4'd0, 8'd0);
        for (int c = 1; c <= 14; c++) begin
            if (c == 5)  chk("loop_hits_rep1", 32'(det_hits), 32'd1);
            if (c == 9)  chk("loop_hits_rep2", 32'(det_hits), 32'd2);
            if (c == 13) chk("loop_done", 32'(done), 32'd1);
            if (c == 14) begin
                chk("loop_hits_rep3", 32'(det_hits), 32'd3);
                chk("loop_idle", 32'(busy), 32'd0);
            end
            if (c != 14) @(negedge clock);
        end
        $display("txn loopback: hits=%0d", det_hits);

        // Continuous single-bit pattern with one gap bit; abort during gap.
        @(negedge clock);
        start_tx(16'h0001, 4'd0, 8'd0, 4'd1, 8'd0);
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("cont_strobe_c%0d", c), 32'(bit_strobe), 32'(c % 2));
            chk($sformatf("cont_busy_c%0d", c), 32'(busy), 32'd1);
            chk($sformatf("cont_done_c%0d", c), 32'(done), 32'd0);
            if (c != 20) @(negedge clock);
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("cont_abort_busy", 32'(busy), 32'd0);
        chk("cont_abort_seq", 32'(sequence_out), 32'd0);
        chk("cont_abort_done", 32'(done), 32'd0);
        $display("txn continuous: aborted");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/iiitb_seq_gen.md
IIITB_SEQ_GEN -- requirements
Module: iiitb_seq_gen

Interface
REQ-001 SHALL have parameter PAT_W, 16, maximum pattern length in bits.
REQ-002 SHALL have parameter DIV_W, 8, width of bit-period divider.
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pattern  input  PAT_W  bits to send, LSB-aligned, used bits pattern[pat_len:0].
REQ-006 SHALL have port pat_len  input  $clog2(PAT_W)  pattern length minus one (0 = 1 bit).
REQ-007 SHALL have port repeat_cnt  input  8  repetitions to send; 0 = continuous until abort.
REQ-008 SHALL have port gap_bits  input  4  idle bit-periods between repetitions; 0 = back-to-back.
REQ-009 SHALL have port baud_div  input  DIV_W  bit period = baud_div+1 clock cycles.
REQ-010 SHALL have ports start_valid input 1 / start_ready output 1, start handshake.
REQ-011 SHALL have port abort  input  1  terminate transmission.
REQ-012 SHALL have port sequence_out  output  1  serial bit stream, registered.
REQ-013 SHALL have ports bit_strobe output 1 (first cycle of each pattern bit), busy output 1, done output 1 (one-cycle pulse).

Function
REQ-014 SHALL implement FSM IDLE -> SEND -> (GAP -> SEND)* -> FINISH -> IDLE.
REQ-015 SHALL assert start_ready only in IDLE with abort low; accept on start_valid && start_ready.
REQ-016 SHALL latch pattern, pat_len, repeat_cnt, gap_bits, baud_div at accept; later input changes ignored until IDLE.
REQ-017 SHALL drive pattern[pat_len] on sequence_out from the cycle after accept, then descending indices to bit 0 (MSB-first).
REQ-018 SHALL hold each bit exactly baud_div+1 cycles; baud_div=0 gives one bit per cycle.
REQ-019 SHALL pulse bit_strobe on the first cycle of each pattern bit, not during GAP.
REQ-020 SHALL, after bit 0, enter GAP for gap_bits bit-periods (skip if 0) when repetitions remain, else FINISH.
REQ-021 SHALL drive sequence_out 0 in IDLE, GAP and FINISH.
REQ-022 SHALL decrement an internal repetition counter at end of each repetition; repeat_cnt=0 never terminates.
REQ-023 SHALL assert busy in SEND, GAP and FINISH.
REQ-024 SHALL pulse done for the single FINISH cycle, immediately after the last bit-period; next cycle IDLE.
REQ-025 SHALL on abort in SEND/GAP enter IDLE next edge, sequence_out 0, busy 0, no done; abort in FINISH lets done complete.
REQ-026 SHALL give abort priority over simultaneous start_valid in IDLE (no accept).

Reset
REQ-027 SHALL on reset enter IDLE immediately: sequence_out 0, bit_strobe 0, busy 0, done 0, start_ready 1 after release, counters 0.
REQ-028 SHALL abandon any transmission on reset mid-operation without done.

Configuration
REQ-029 SHALL honour macro IIITB_SEQ_GEN_PRBS_EN: when defined, GAP bits come from a PRBS-7 LFSR (x^7+x^6+1, seed 7'h7F at reset, one step per gap bit-period, not reseeded per transmission); when undefined, GAP bits are 0 and no LFSR exists.

Structure
REQ-030 SHALL place the state enum, PAT_W/DIV_W defaults and LFSR polynomial/seed constants in package iiitb_seq_gen_pkg.
REQ-031 SHALL use one sub-module iiitb_seq_gen_baud: down-counter producing a one-cycle bit tick every baud_div+1 cycles, restartable at accept.

Verification
REQ-032 SHALL cover: pattern 16'h000B, pat_len 3, baud_div 0, repeat 1, gap 0 -> sequence_out 1,0,1,1 on cycles 1-4 after accept, done at cycle 5.
REQ-033 SHALL cover: same with baud_div 2 -> each bit held 3 cycles, bit_strobe at cycles 1,4,7,10, done at 13.
REQ-034 SHALL cover: repeat 2, gap 2, baud_div 0 -> 1011 00 1011 then done; with PRBS_EN the two gap bits equal the first two LFSR outputs after seed 7'h7F.
REQ-035 SHALL cover: abort on 2nd bit -> sequence_out 0 and busy 0 next cycle, no done, start_ready 1 the following cycle.
REQ-036 SHALL cover: reset asserted mid-SEND between edges -> outputs reset immediately; start_valid with abort high in IDLE -> not accepted.
REQ-037 SHALL cover: loopback into iiitb_sd_fsm sequence_in with pattern equal to its target sequence, repeat 3 -> detector_out asserts once per repetition.
